// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
// Optional feature macro: PC_ALIGN_CHECK_EN (word-aligns redirect targets
// and raises a one-cycle misalign flag).
package pc_ctrl_pkg;

    localparam int unsigned PC_W = 20;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 20'h00000;
    localparam logic [PC_W-1:0] PC_STEP_DEFAULT  = 20'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } pc_state_t;

    // Clear the byte-offset bits so the address points at a 32-bit word.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/Adder.sv
// Plain 20-bit modulo adder shared by PC increment and redirect target.
module Adder
    import pc_ctrl_pkg::*;
(
    input  logic [PC_W-1:0] op1,
    input  logic [PC_W-1:0] op2,
    output logic [PC_W-1:0] result
);

    // Carry out is deliberately discarded: PC arithmetic wraps silently.
    assign result = op1 + op2;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: owns the PC register, shares one adder between
// sequential increment and redirect target, inserts one bubble per redirect.
// Optional feature macro: PC_ALIGN_CHECK_EN.
module fetch_pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_base,
    input  logic [PC_W-1:0] redirect_offset,
    output logic            redirect_ack,
    output logic [PC_W-1:0] pc_out,
    output logic            pc_valid,
    output logic            misalign
);

    pc_state_t       state_q;
    logic [PC_W-1:0] pc_q;
    logic            pc_valid_q;
    logic            misalign_q;

    logic            redir_sel_c;
    logic [PC_W-1:0] op1_c;
    logic [PC_W-1:0] op2_c;
    logic [PC_W-1:0] sum_c;
    logic [PC_W-1:0] target_c;
    logic            target_misalign_c;

    // A redirect is only honoured in RUN; BOOT and REDIR ignore the request.
    assign redir_sel_c  = (state_q == RUN) && redirect_valid;
    assign redirect_ack = redir_sel_c && !rst;

    // Operand mux in front of the single shared adder.
    always_comb begin
        op1_c = pc_q;
        op2_c = PC_STEP;
        if (redir_sel_c) begin
            op1_c = redirect_base;
            op2_c = redirect_offset;
        end
    end

    Adder u_adder (
        .op1    (op1_c),
        .op2    (op2_c),
        .result (sum_c)
    );

`ifdef PC_ALIGN_CHECK_EN
    // Force redirect targets onto a word boundary and flag the raw offset.
    always_comb begin
        target_c          = word_align(sum_c);
        target_misalign_c = |sum_c[1:0];
    end
`else
    // Targets pass through untouched; the misalign flag never fires.
    always_comb begin
        target_c          = sum_c;
        target_misalign_c = 1'b0;
    end
`endif

    // Control FSM and PC/valid/misalign registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    pc_valid_q <= 1'b1;
                    state_q    <= RUN;
                end
                RUN: begin
                    if (redirect_valid) begin
                        // Redirect wins over a concurrent fetch; that fetch is dropped.
                        pc_q       <= target_c;
                        pc_valid_q <= 1'b0;
                        misalign_q <= target_misalign_c;
                        state_q    <= REDIR;
                    end else if (pc_valid_q && fetch_ready) begin
                        pc_q <= sum_c;
                    end
                end
                REDIR: begin
                    pc_valid_q <= 1'b1;
                    state_q    <= RUN;
                end
                default: begin
                    state_q    <= BOOT;
                    pc_q       <= RESET_PC;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out   = pc_q;
    assign pc_valid = pc_valid_q;
    assign misalign = misalign_q;

endmodule
